// File: rtl/vga_pkg.sv
// Shared 640x480@60 timing constants and pixel/coordinate types for the VGA scan path.
package vga_pkg;

    localparam int unsigned COORD_W = 10;
    localparam int unsigned COLOR_W = 8;

    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned H_FP     = 16;
    localparam int unsigned H_SYNC   = 96;
    localparam int unsigned H_BP     = 48;
    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    localparam int unsigned V_ACTIVE = 480;
    localparam int unsigned V_FP     = 10;
    localparam int unsigned V_SYNC   = 2;
    localparam int unsigned V_BP     = 33;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Sync pulses sit right after the front porch; bounds are inclusive.
    localparam int unsigned H_SYNC_START = H_ACTIVE + H_FP;
    localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
    localparam int unsigned V_SYNC_START = V_ACTIVE + V_FP;
    localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

    typedef logic [COORD_W-1:0] coord_t;

    typedef struct packed {
        logic [COLOR_W-1:0] r;
        logic [COLOR_W-1:0] g;
        logic [COLOR_W-1:0] b;
    } rgb_t;

endpackage

// File: rtl/vga_scan_timing_if.sv
// Raster/renderer and DAC-side signal bundle of the scan timing block.
interface vga_scan_timing_if;
    import vga_pkg::*;

    logic [COLOR_W-1:0] r_in;
    logic [COLOR_W-1:0] g_in;
    logic [COLOR_W-1:0] b_in;
    coord_t             x_cnt;
    coord_t             y_cnt;
    logic               active;
    logic               pix_en;
    logic               frame_start;
    logic               vga_clk;
    logic               vga_hs;
    logic               vga_vs;
    logic               vga_blank_n;
    logic               vga_sync_n;
    logic [COLOR_W-1:0] vga_r;
    logic [COLOR_W-1:0] vga_g;
    logic [COLOR_W-1:0] vga_b;

    modport master (
        input  r_in, g_in, b_in,
        output x_cnt, y_cnt, active, pix_en, frame_start,
        output vga_clk, vga_hs, vga_vs, vga_blank_n, vga_sync_n,
        output vga_r, vga_g, vga_b
    );

    modport slave (
        output r_in, g_in, b_in,
        input  x_cnt, y_cnt, active, pix_en, frame_start,
        input  vga_clk, vga_hs, vga_vs, vga_blank_n, vga_sync_n,
        input  vga_r, vga_g, vga_b
    );

endinterface

// File: rtl/vga_pix_div.sv
// System-clock to pixel-rate divider: one-clk pix_en strobe plus the DAC pixel clock.
module vga_pix_div #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic pix_en,
    output logic vga_clk
);

    localparam int unsigned DIV_W = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_nxt;

    always_comb begin
        div_nxt = (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
    end

    // Strobe and clock are decoded from the next count so they line up with div_cnt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            pix_en  <= 1'b0;
            vga_clk <= 1'b0;
        end else begin
            div_cnt <= div_nxt;
            pix_en  <= (div_nxt == DIV_LAST);
            vga_clk <= (div_nxt >= DIV_HALF);
        end
    end

endmodule

// File: rtl/vga_scan_timing.sv
// Free-running VGA raster counters, sync/blank decode and one-pixel output register to the DAC.
module vga_scan_timing
    import vga_pkg::coord_t, vga_pkg::rgb_t;
#(
    parameter int unsigned CLK_DIV  = 2,
    parameter int unsigned H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int unsigned H_FP     = vga_pkg::H_FP,
    parameter int unsigned H_SYNC   = vga_pkg::H_SYNC,
    parameter int unsigned H_BP     = vga_pkg::H_BP,
    parameter int unsigned V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int unsigned V_FP     = vga_pkg::V_FP,
    parameter int unsigned V_SYNC   = vga_pkg::V_SYNC,
    parameter int unsigned V_BP     = vga_pkg::V_BP
) (
    input  logic              clk,
    input  logic              rst_n,
    vga_scan_timing_if.master bus
);

    localparam int unsigned CW      = vga_pkg::COORD_W;
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam coord_t H_VIS  = CW'(H_ACTIVE);
    localparam coord_t V_VIS  = CW'(V_ACTIVE);
    localparam coord_t H_LAST = CW'(H_TOTAL - 1);
    localparam coord_t V_LAST = CW'(V_TOTAL - 1);
    localparam coord_t HS_LO  = CW'(H_ACTIVE + H_FP);
    localparam coord_t HS_HI  = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam coord_t VS_LO  = CW'(V_ACTIVE + V_FP);
    localparam coord_t VS_HI  = CW'(V_ACTIVE + V_FP + V_SYNC - 1);

    coord_t h_cnt;
    coord_t v_cnt;
    logic   pix_en;
    logic   vga_clk;
    logic   h_wrap;
    logic   v_wrap;
    logic   active_c;
    logic   hs_raw;
    logic   vs_raw;
    rgb_t   rgb_in;
    rgb_t   rgb_q;
    logic   hs_q;
    logic   vs_q;
    logic   blank_n_q;

    vga_pix_div #(.CLK_DIV(CLK_DIV)) u_pix_div (
        .clk     (clk),
        .rst_n   (rst_n),
        .pix_en  (pix_en),
        .vga_clk (vga_clk)
    );

    // Decode of the current coordinate: visibility and raw (unregistered) sync levels.
    always_comb begin
        h_wrap   = (h_cnt == H_LAST);
        v_wrap   = (v_cnt == V_LAST);
        active_c = (h_cnt < H_VIS) && (v_cnt < V_VIS);
        hs_raw   = !((h_cnt >= HS_LO) && (h_cnt <= HS_HI));
        vs_raw   = !((v_cnt >= VS_LO) && (v_cnt <= VS_HI));
        rgb_in.r = bus.r_in;
        rgb_in.g = bus.g_in;
        rgb_in.b = bus.b_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_en) begin
            h_cnt <= h_wrap ? '0 : h_cnt + CW'(1);
            if (h_wrap) begin
                v_cnt <= v_wrap ? '0 : v_cnt + CW'(1);
            end
        end
    end

    // Sync, blank and colour are captured together so they reach the DAC in the same slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_q      <= 1'b1;
            vs_q      <= 1'b1;
            blank_n_q <= 1'b0;
            rgb_q     <= '0;
        end else if (pix_en) begin
            hs_q      <= hs_raw;
            vs_q      <= vs_raw;
            blank_n_q <= active_c;
            rgb_q     <= active_c ? rgb_in : '0;
        end
    end

    assign bus.x_cnt       = h_cnt;
    assign bus.y_cnt       = v_cnt;
    assign bus.active      = active_c;
    assign bus.pix_en      = pix_en;
    assign bus.frame_start = pix_en && h_wrap && v_wrap;
    assign bus.vga_clk     = vga_clk;
    assign bus.vga_hs      = hs_q;
    assign bus.vga_vs      = vs_q;
    assign bus.vga_blank_n = blank_n_q;
    assign bus.vga_sync_n  = 1'b0;
    assign bus.vga_r       = rgb_q.r;
    assign bus.vga_g       = rgb_q.g;
    assign bus.vga_b       = rgb_q.b;

endmodule

// File: tb/tb_vga_scan_timing.sv
// Scoreboard bench for vga_scan_timing on a shrunken raster, checked against an arithmetic scan model.
module tb_vga_scan_timing;

    localparam int CD  = 3;
    localparam int HA  = 16;
    localparam int HF  = 2;
    localparam int HSW = 3;
    localparam int HB  = 4;
    localparam int VA  = 6;
    localparam int VF  = 2;
    localparam int VSW = 2;
    localparam int VB  = 3;
    localparam int HT  = HA + HF + HSW + HB;
    localparam int VT  = VA + VF + VSW + VB;
    localparam int FRAME_CLKS = HT * VT * CD;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       active;
        logic       pix_en;
        logic       frame_start;
        logic       vga_clk;
        logic       hs;
        logic       vs;
        logic       blank_n;
        logic       sync_n;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } obs_t;

    logic clk;
    logic rst_n;
    vga_scan_timing_if bus();

    vga_scan_timing #(
        .CLK_DIV(CD), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    obs_t exp_q[$];

    // Model state: clocks elapsed since reset release, and the last captured pixel.
    int         t = 0;
    int         mode = 2;
    int         exp_fs = 0;
    logic       q_hs = 1'b1;
    logic       q_vs = 1'b1;
    logic       q_bn = 1'b0;
    logic [7:0] q_r = '0;
    logic [7:0] q_g = '0;
    logic [7:0] q_b = '0;

    function automatic obs_t model_obs();
        obs_t o;
        int div, p, h, v;
        div = t % CD;
        p = t / CD;
        h = p % HT;
        v = (p / HT) % VT;
        o.x = 10'(h);
        o.y = 10'(v);
        o.active = (h < HA) && (v < VA);
        o.pix_en = (div == CD - 1);
        o.vga_clk = (div >= CD / 2);
        o.frame_start = o.pix_en && (h == HT - 1) && (v == VT - 1);
        o.hs = q_hs;
        o.vs = q_vs;
        o.blank_n = q_bn;
        o.sync_n = 1'b0;
        o.r = q_r;
        o.g = q_g;
        o.b = q_b;
        return o;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.x = bus.x_cnt;
        o.y = bus.y_cnt;
        o.active = bus.active;
        o.pix_en = bus.pix_en;
        o.frame_start = bus.frame_start;
        o.vga_clk = bus.vga_clk;
        o.hs = bus.vga_hs;
        o.vs = bus.vga_vs;
        o.blank_n = bus.vga_blank_n;
        o.sync_n = bus.vga_sync_n;
        o.r = bus.vga_r;
        o.g = bus.vga_g;
        o.b = bus.vga_b;
        return o;
    endfunction

    function automatic void report(input string name, input obs_t a, input obs_t e);
        $display("FAIL %s @%0t got x=%0d y=%0d act=%b pe=%b fs=%b vclk=%b hs=%b vs=%b bn=%b sn=%b rgb=%h/%h/%h exp x=%0d y=%0d act=%b pe=%b fs=%b vclk=%b hs=%b vs=%b bn=%b sn=%b rgb=%h/%h/%h",
                 name, $time, a.x, a.y, a.active, a.pix_en, a.frame_start, a.vga_clk, a.hs, a.vs,
                 a.blank_n, a.sync_n, a.r, a.g, a.b, e.x, e.y, e.active, e.pix_en, e.frame_start,
                 e.vga_clk, e.hs, e.vs, e.blank_n, e.sync_n, e.r, e.g, e.b);
    endfunction

    // One clock of stimulus; pushes the state expected just after the next rising edge.
    task automatic step(input logic rst_val);
        logic       was;
        logic [7:0] ri, gi, bi;
        obs_t       a, e;
        int         p, h, v;
        bit         act;
        @(negedge clk);
        was = rst_n;
        rst_n = rst_val;
        if (!rst_val) begin
            t = 0;
            q_hs = 1'b1; q_vs = 1'b1; q_bn = 1'b0;
            q_r = '0; q_g = '0; q_b = '0;
        end
        if (was && !rst_val) begin
            #1;
            a = sample();
            e = model_obs();
            checks++;
            if (a !== e) begin
                errors++;
                report("async_reset", a, e);
            end
        end
        case (mode)
            0: begin ri = 8'hFF; gi = 8'h12; bi = 8'h34; end
            1: begin ri = bus.x_cnt[7:0]; gi = 8'($urandom); bi = 8'($urandom); end
            default: begin ri = 8'($urandom); gi = 8'($urandom); bi = 8'($urandom); end
        endcase
        bus.r_in = ri;
        bus.g_in = gi;
        bus.b_in = bi;
        if (rst_val) begin
            if (t % CD == CD - 1) begin
                p = t / CD;
                h = p % HT;
                v = (p / HT) % VT;
                act = (h < HA) && (v < VA);
                q_hs = !((h >= HA + HF) && (h <= HA + HF + HSW - 1));
                q_vs = !((v >= VA + VF) && (v <= VA + VF + VSW - 1));
                q_bn = act;
                q_r = act ? ((mode == 1) ? 8'(h) : ri) : 8'h00;
                q_g = act ? gi : 8'h00;
                q_b = act ? bi : 8'h00;
            end
            t++;
        end
        e = model_obs();
        if (e.frame_start) exp_fs++;
        exp_q.push_back(e);
    endtask

    // Monitor: pops one expectation per clock, plus pulse-width and frame-period checks.
    int cyc = 0;
    int last_fs = -1;
    int got_fs = 0;
    int hs_run = 0;
    int vs_run = 0;
    bit hs_ok = 0;
    bit vs_ok = 0;

    always @(posedge clk) begin
        obs_t a, e;
        #1;
        cyc++;
        a = sample();
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (a !== e) begin
                errors++;
                report("scan", a, e);
            end
        end
        if (!rst_n) begin
            last_fs = -1;
            hs_run = 0; hs_ok = 0;
            vs_run = 0; vs_ok = 0;
        end else begin
            if (a.frame_start) begin
                got_fs++;
                if (last_fs >= 0) begin
                    checks++;
                    if (cyc - last_fs != FRAME_CLKS) begin
                        errors++;
                        $display("FAIL frame_period got=%0d exp=%0d", cyc - last_fs, FRAME_CLKS);
                    end
                end
                last_fs = cyc;
            end
            if (!a.hs) begin
                if (hs_run == 0) hs_ok = 1;
                hs_run++;
            end else begin
                if (hs_run > 0 && hs_ok) begin
                    checks++;
                    if (hs_run != HSW * CD) begin
                        errors++;
                        $display("FAIL hs_width got=%0d exp=%0d", hs_run, HSW * CD);
                    end
                end
                hs_run = 0;
            end
            if (!a.vs) begin
                if (vs_run == 0) vs_ok = 1;
                vs_run++;
            end else begin
                if (vs_run > 0 && vs_ok) begin
                    checks++;
                    if (vs_run != VSW * HT * CD) begin
                        errors++;
                        $display("FAIL vs_width got=%0d exp=%0d", vs_run, VSW * HT * CD);
                    end
                end
                vs_run = 0;
            end
        end
    end

    initial begin
        bit found;
        rst_n = 1'b0;
        bus.r_in = '0;
        bus.g_in = '0;
        bus.b_in = '0;

        mode = 2;
        repeat (10) step(1'b0);

        mode = 0;
        repeat (FRAME_CLKS + 50) step(1'b1);

        mode = 1;
        repeat (HT * CD * 3) step(1'b1);

        // Run to mid-pixel at (10,3) of a later frame, then pulse reset.
        mode = 2;
        found = 0;
        for (int i = 0; i < 2 * FRAME_CLKS && !found; i++) begin
            step(1'b1);
            if ((t % CD == 1) && ((t / CD) % HT == 10) && (((t / CD) / HT) % VT == 3)) found = 1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL reach_mid_frame got=timeout exp=(10,3)");
        end
        repeat (3) step(1'b0);
        repeat (FRAME_CLKS + 100) step(1'b1);

        @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain got=%0d exp=0", exp_q.size());
        end
        checks++;
        if (got_fs != exp_fs) begin
            errors++;
            $display("FAIL frame_count got=%0d exp=%0d", got_fs, exp_fs);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
